// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e  : sequencer FSM encoding (RUN=0, MUL_WAIT=1, MEM_WAIT=2)
//   REG_ZERO : architectural $zero register index, never a real hazard source
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   id_rs, id_rt  : source register fields of the instruction in ID
//   id_uses_rt    : ID instruction actually reads rt
//   ex_mem_read   : a load is in EX
//   ex_rt         : destination register of that load
//   load_use      : ID must wait one cycle for the load result
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  // A load targeting $zero writes nothing, so it can never feed a consumer.
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives write enables and bubble controls of PC, IF/ID, ID/EX and EX/MEM.
// Inputs : clk, rst (sync, active-high), ID source fields, EX load info,
//          ex_mul_start, branch_taken, mem_req/mem_ready.
// Outputs: *_write / *_flush per pipeline register, mul_done pulse,
//          state_o (debug), stall_cnt (saturating count of pc_write=0 cycles).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rt,
  input  logic               ex_mul_start,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_flush,
  output logic               ex_mem_write,
  output logic               ex_mem_flush,
  output logic               mul_done,
  output logic [1:0]         state_o,
  output logic [STALL_W-1:0] stall_cnt
);

  // Start cycle plus MUL_CYCLES-1 MUL_WAIT cycles; the last one has count 0.
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q;
  logic               load_use;
  logic               mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mul_done     = 1'b0;

    if (rst) begin
      state_d      = ST_RUN;
      mul_cnt_d    = '0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_d      = ST_MEM_WAIT;
          end else if (ex_mul_start) begin
            // Hold the multiply in EX and feed bubbles into MEM.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mul_cnt_d    = MulLoad;
            state_d      = ST_MUL_WAIT;
          end else if (branch_taken) begin
            // Squash wrong-path fetches; also overrides any load-use bubble.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          if (mul_cnt_q == '0) begin
            mul_done = 1'b1;
            state_d  = ST_RUN;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mul_cnt_d    = mul_cnt_q - CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
      end
    end
  end

  assign state_o   = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
